pipe_buffer_chain: RTL and testbench

PIPE_BUFFER_CHAIN -- requirements
Module: pipe_buffer_chain

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_stage.sv | 53 +++++
 rtl/pipe_buffer_chain.sv | 127 ++++++++++++
 tb/tb_pipe_buffer_chain.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants and helpers for the pipe_buffer_chain block.
//   STAGES_MAX : largest supported number of register stages
//   OCC_W      : width of the occupancy output (holds 0..STAGES_MAX)
//   PERF_W     : width of the optional performance counters
//   popcount() : number of set bits in a STAGES_MAX-wide vector
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int STAGES_MAX = 8;
    localparam int OCC_W      = 4;
    localparam int PERF_W     = 32;

    function automatic logic [OCC_W-1:0] popcount(input logic [STAGES_MAX-1:0] bits);
        logic [OCC_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < STAGES_MAX; i++) begin
            sum = sum + OCC_W'(bits[i]);
        end
        return sum;
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// One slot of the buffer chain: a valid flag plus a payload register.
//   Clk        : clock, rising edge
//   Rst        : synchronous active-high reset (clears valid)
//   load       : an item arrives this cycle (wins over drain and kill)
//   drain      : the held item moves downstream this cycle
//   kill       : the held item is discarded this cycle
//   d          : incoming payload
//   valid, q   : registered valid flag and payload
// Parameter CLEAR_DATA makes the payload register clear on reset; it is set
// only for the output-side stage so the block's out_data reads 0 after reset.
// -----------------------------------------------------------------------------
module pipe_stage #(
    parameter int WIDTH      = 16,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load,
    input  logic             drain,
    input  logic             kill,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values of its neighbours, independent of process order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain || kill) begin
            valid <= 1'b0;
        end
    end

    // NOTE: payload registers carry no reset (they are qualified by valid);
    // only the output stage is cleared so the visible out_data is defined.
    // Writing only on load keeps an empty slot's payload from toggling.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            if (CLEAR_DATA) begin
                q <= '0;
            end
        end else if (load) begin
            q <= d;
        end
    end

endmodule : pipe_stage

// File: rtl/pipe_buffer_chain.sv
// -----------------------------------------------------------------------------
// pipe_buffer_chain
// A chain of STAGES valid/ready register slices with bubble collapse and a
// per-stage kill mask. Items move one stage per cycle towards the output and
// fill any empty slot ahead of them, even while the consumer stalls.
//
// Ports
//   Clk        : clock, all state on the rising edge
//   Rst        : synchronous active-high reset
//   in_valid   : upstream item present
//   in_data    : upstream payload (WIDTH)
//   in_ready   : stage 0 can take an item this cycle (forced 0 in reset)
//   out_valid  : last stage holds an item (registered)
//   out_data   : last-stage payload (registered, WIDTH)
//   out_ready  : downstream consumes the presented item this cycle
//   flush      : per-stage kill mask, bit k discards the item in stage k
//   occupancy  : number of valid stages
//   stall_cnt  : cycles with out_valid=1 and out_ready=0      (optional)
//   flush_cnt  : total number of valid items discarded by flush (optional)
//
// Build option: define PIPE_PERF_CNT_EN to add stall_cnt and flush_cnt.
// -----------------------------------------------------------------------------
module pipe_buffer_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 16,   // 1..256
    parameter int STAGES = 4     // 1..STAGES_MAX
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    input  logic [STAGES-1:0] flush,
    output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);

    logic [STAGES-1:0]            valid;   // registered valid flags
    logic [STAGES-1:0][WIDTH-1:0] data;    // registered payloads
    logic [STAGES-1:0]            hold;    // valid and not killed this cycle
    logic [STAGES-1:0]            adv;     // stage hands its item forward
    logic                         room;    // running "slot ahead will be free"
    logic                         head_room;

    // Walk from the output side towards the input. 'room' says whether the
    // slot ahead of stage k is free at the next edge: it is free when the
    // downstream consumes (last stage) or when the next stage is empty,
    // killed, or itself advancing. A killed stage counts as empty, so the
    // stage behind it refills it in the same cycle.
    // NOTE: this combinational block uses blocking '=' and assigns every
    // output before the loop, so no latch is inferred and 'room' chains
    // correctly from one iteration to the next.
    always_comb begin
        hold      = valid & ~flush;
        adv       = '0;
        room      = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = hold[k] & room;
            room   = ~hold[k] | room;
        end
        head_room = room;
    end

    // Stage 0 takes an item when it ends the cycle empty; depends on
    // out_ready through the advance chain, which is allowed.
    assign in_ready = ~Rst & head_room;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             stage_load;
        logic [WIDTH-1:0] stage_d;

        if (k == 0) begin : g_head
            assign stage_load = in_valid & in_ready;
            assign stage_d    = in_data;
        end else begin : g_body
            assign stage_load = adv[k-1];
            assign stage_d    = data[k-1];
        end

        pipe_stage #(
            .WIDTH      (WIDTH),
            .CLEAR_DATA (k == STAGES - 1)
        ) u_stage (
            .Clk   (Clk),
            .Rst   (Rst),
            .load  (stage_load),
            .drain (adv[k]),
            .kill  (flush[k]),
            .d     (stage_d),
            .valid (valid[k]),
            .q     (data[k])
        );
    end

    assign out_valid = valid[STAGES-1];
    assign out_data  = data[STAGES-1];
    assign occupancy = popcount(STAGES_MAX'(valid));

`ifdef PIPE_PERF_CNT_EN
    logic [OCC_W-1:0] killed;

    // Only stages that actually held an item count as discarded.
    assign killed = popcount(STAGES_MAX'(valid & flush));

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
            flush_cnt <= flush_cnt + PERF_W'(killed);
        end
    end
`endif

endmodule : pipe_buffer_chain

// File: tb/tb_pipe_buffer_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_buffer_chain
// Self-checking bench for pipe_buffer_chain (WIDTH=16, STAGES=4). A slot-array
// reference model moves items into free slots ahead of them each cycle and is
// compared against the DUT on the falling edge of every cycle. Directed
// scenarios (streaming, backpressure, bubble collapse, single kill, full flush
// with push, reset mid-stream) are followed by a randomized run.
// Counter checks are compiled in when PIPE_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_buffer_chain;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic              Clk       = 1'b0;
    logic              Rst       = 1'b1;
    logic              in_valid  = 1'b0;
    logic [WIDTH-1:0]  in_data   = '0;
    logic              out_ready = 1'b0;
    logic [STAGES-1:0] flush     = '0;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [3:0]        occupancy;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
`endif

    always #5 Clk = ~Clk;

    pipe_buffer_chain #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit               m_known = 1'b0;
    bit               m_valid [STAGES];
    logic [WIDTH-1:0] m_data  [STAGES];
    logic [31:0]      m_stall;
    logic [31:0]      m_flc;
    bit               n_valid [STAGES];
    logic [WIDTH-1:0] n_data  [STAGES];
    logic [31:0]      n_stall;
    logic [31:0]      n_flc;
    bit               exp_ready;
    logic [WIDTH-1:0] seen[$];

    function automatic int model_occ();
        int n = 0;
        for (int k = 0; k < STAGES; k++) n += int'(m_valid[k]);
        return n;
    endfunction

    // Next state from the current inputs: kill flagged items, pop the head
    // if the consumer takes it, then let every surviving item step into the
    // slot ahead if nobody occupies it, and finally admit a new item into
    // slot 0 if it ends up free.
    task automatic model_next();
        bit left [STAGES];
        int killed;
        bit popped;
        n_data = m_data;
        for (int k = 0; k < STAGES; k++) n_valid[k] = 1'b0;
        if (Rst) begin
            n_data[STAGES-1] = '0;
            n_stall   = '0;
            n_flc     = '0;
            exp_ready = 1'b0;
            return;
        end
        killed = 0;
        for (int k = 0; k < STAGES; k++) begin
            left[k] = m_valid[k];
            if (flush[k] && left[k]) begin
                left[k] = 1'b0;
                killed++;
            end
        end
        n_stall = m_stall + ((m_valid[STAGES-1] && !out_ready) ? 32'd1 : 32'd0);
        n_flc   = m_flc + 32'(killed);
        popped  = left[STAGES-1] && out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (left[k]) begin
                if (k == STAGES - 1) begin
                    if (!popped) n_valid[k] = 1'b1;
                end else if (!n_valid[k+1]) begin
                    n_valid[k+1] = 1'b1;
                    n_data[k+1]  = m_data[k];
                end else begin
                    n_valid[k] = 1'b1;
                end
            end
        end
        exp_ready = !n_valid[0];
        if (in_valid && exp_ready) begin
            n_valid[0] = 1'b1;
            n_data[0]  = in_data;
        end
    endtask

    // One clock cycle: drive, compare on the falling edge, advance the model.
    task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit ordy,
                         input logic [STAGES-1:0] fl, input bit r, output bit acc);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        Rst       = r;
        model_next();
        @(negedge Clk);
        if (m_known) begin
            check("out_valid", 64'(out_valid), 64'(m_valid[STAGES-1]));
            check("out_data", 64'(out_data), 64'(m_data[STAGES-1]));
            check("occupancy", 64'(occupancy), 64'(model_occ()));
            check("in_ready", 64'(in_ready), 64'(exp_ready));
`ifdef PIPE_PERF_CNT_EN
            check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            check("flush_cnt", 64'(flush_cnt), 64'(m_flc));
`endif
        end
        if (out_valid === 1'b1 && ordy && !fl[STAGES-1] && !r) seen.push_back(out_data);
        acc = v && exp_ready;
        @(posedge Clk);
        m_valid = n_valid;
        m_data  = n_data;
        m_stall = n_stall;
        m_flc   = n_flc;
        if (r) m_known = 1'b1;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int first;
        int idx;
        int n_acc;
        logic [WIDTH-1:0] exp_kill [3];
        exp_kill[0] = 16'h000A;
        exp_kill[1] = 16'h000C;
        exp_kill[2] = 16'h000D;
        for (int k = 0; k < STAGES; k++) m_valid[k] = 1'b0;

        // Reset with an item offered: it must be lost.
        repeat (2) cycle(1'b1, 16'h1234, 1'b1, '0, 1'b1, acc);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);

        // Streaming 0x0001..0x0010 with out_ready held high.
        seen.delete();
        first = -1;
        n_acc = 0;
        for (int c = 0; c < 24; c++) begin
            cycle(c < 16, WIDTH'(c + 1), 1'b1, '0, 1'b0, acc);
            if (acc) n_acc++;
            if (out_valid === 1'b1 && first < 0) first = c + 1;
        end
        check("stream_first_valid", 64'(first), 64'd4);
        check("stream_accepts", 64'(n_acc), 64'd16);
        check("stream_count", 64'(seen.size()), 64'd16);
        for (int i = 0; i < seen.size() && i < 16; i++)
            check("stream_order", 64'(seen[i]), 64'(i + 1));

        // Backpressure: 5 items offered while out_ready is low.
        cycle(1'b0, '0, 1'b0, '0, 1'b1, acc);
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            cycle(idx < 5, WIDTH'(16'h21 + idx), 1'b0, '0, 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_accepted", 64'(idx), 64'd4);
        check("bp_occ", 64'(occupancy), 64'd4);
        check("bp_in_ready", 64'(in_ready), 64'd0);
`ifdef PIPE_PERF_CNT_EN
        check("bp_stall_cnt", 64'(stall_cnt), 64'd2);
`endif
        seen.delete();
        for (int c = 0; c < 12; c++) begin
            cycle(idx < 5, WIDTH'(16'h21 + idx), 1'b1, '0, 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_drain_count", 64'(seen.size()), 64'd5);
        for (int i = 0; i < seen.size() && i < 5; i++)
            check("bp_drain_order", 64'(seen[i]), 64'(16'h21 + i));

        // Bubble collapse: one item, consumer stalled.
        cycle(1'b0, '0, 1'b0, '0, 1'b1, acc);
        cycle(1'b1, 16'h0077, 1'b0, '0, 1'b0, acc);
        repeat (3) cycle(1'b0, '0, 1'b0, '0, 1'b0, acc);
        check("bubble_out_valid", 64'(out_valid), 64'd1);
        check("bubble_out_data", 64'(out_data), 64'h77);
        check("bubble_occ", 64'(occupancy), 64'd1);
        check("bubble_in_ready", 64'(in_ready), 64'd1);

        // Single-stage kill of 0xB in stage 2.
        cycle(1'b0, '0, 1'b0, '0, 1'b1, acc);
        for (int c = 0; c < 4; c++) cycle(1'b1, WIDTH'(16'hA + c), 1'b0, '0, 1'b0, acc);
        cycle(1'b0, '0, 1'b0, 4'b0100, 1'b0, acc);
        check("kill_occ", 64'(occupancy), 64'd3);
`ifdef PIPE_PERF_CNT_EN
        check("kill_flush_cnt", 64'(flush_cnt), 64'd1);
`endif
        seen.delete();
        repeat (8) cycle(1'b0, '0, 1'b1, '0, 1'b0, acc);
        check("kill_count", 64'(seen.size()), 64'd3);
        for (int i = 0; i < seen.size() && i < 3; i++)
            check("kill_order", 64'(seen[i]), 64'(exp_kill[i]));

        // Full flush with a concurrent push of 0xEE.
        for (int c = 0; c < 4; c++) cycle(1'b1, WIDTH'(16'h31 + c), 1'b0, '0, 1'b0, acc);
        cycle(1'b1, 16'h00EE, 1'b0, 4'b1111, 1'b0, acc);
        check("ff_accept", 64'(acc), 64'd1);
        check("ff_occ", 64'(occupancy), 64'd1);
        first = -1;
        for (int c = 1; c < 8; c++) begin
            if (out_valid === 1'b1 && first < 0) begin
                first = c;
                check("ff_out_data", 64'(out_data), 64'hEE);
            end
            cycle(1'b0, '0, 1'b1, '0, 1'b0, acc);
        end
        check("ff_latency", 64'(first), 64'd4);

        // Reset with a full, stalled pipe.
        for (int c = 0; c < 6; c++) cycle(1'b1, WIDTH'(16'h41 + c), 1'b0, '0, 1'b0, acc);
        cycle(1'b1, 16'h0099, 1'b1, 4'b0011, 1'b1, acc);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_occ", 64'(occupancy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
`ifdef PIPE_PERF_CNT_EN
        check("mid_rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("mid_rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 3) != 0,
                  WIDTH'($urandom),
                  $urandom_range(0, 2) != 0,
                  ($urandom_range(0, 9) == 0) ? STAGES'($urandom) : '0,
                  $urandom_range(0, 299) == 0,
                  acc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipe_buffer_chain
